mips_boot_loader: RTL and testbench
===================================

// Module: mips_boot_loader
// PURPOSE
//  Upstream loader for the single-cycle MIPS core. Receives a byte stream over a
//  valid/ready interface and assembles little-endian 32-bit words. Writes each word
//  into program memory through a write port. Holds the processor in reset until a
//  complete, valid image has been written.
// PARAMETERS
//  MEMORY_DEPTH  32  program-memory size in 32-bit words; maximum accepted image length
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  start         in   1   one-cycle pulse: begin a load; ignored while Busy=1
//  RxData        in   8   incoming byte
//  RxValid       in   1   RxData valid
//  RxReady       out  1   loader can accept a byte
//  MemWrite      out  1   one-cycle program-memory write strobe
//  MemAddress    out  32  byte address of the write (word_index*4)
//  MemWriteData  out  32  assembled instruction word
//  CPUReset      out  1   reset to the processor (1 = held in reset)
//  Busy          out  1   load in progress
//  Done          out  1   image loaded; processor released
//  Error         out  1   rejected image length
//  WordCount     out  16  words written in the current load
// BEHAVIOUR
//  Reset values: state=IDLE, CPUReset=1, RxReady=0, MemWrite=0, MemAddress=0,
//   MemWriteData=0, Busy=0, Done=0, Error=0, WordCount=0. Reset wins over every
//   other input.
//  Byte accept: a byte is taken on a rising edge where RxValid&&RxReady. No combinational path from RxValid to RxReady.
//  Image format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N
//   bytes. Word byte k goes to bits [8k+7:8k].
//  FSM states:
//   IDLE    RxReady=0. start -> LEN_LO: set Busy=1, CPUReset=1, clear Done, Error and WordCount.
//   LEN_LO  RxReady=1. On accept, latch N[7:0] -> LEN_HI.
//   LEN_HI  RxReady=1. On accept, latch N[15:8].
//           N==0 or N>MEMORY_DEPTH -> ERROR; otherwise -> DATA with byte_idx=0.
//   DATA    RxReady=1. On accept, store the byte at byte_idx and increment byte_idx.
//           On the 4th byte -> WRITE.
//   WRITE   RxReady=0. MemWrite=1 for exactly this cycle.
//           MemAddress=WordCount<<2; MemWriteData=assembled word.
//           Next edge: WordCount+1. -> DONE if WordCount+1==N, else -> DATA.
//   DONE    Busy=0, Done=1; CPUReset=0 from the first DONE cycle. start -> LEN_LO,
//           which re-asserts CPUReset the next cycle.
//   ERROR   Busy=0, Error=1, CPUReset stays 1. start -> LEN_LO.
//  Latency: the write strobe comes 1 cycle after the 4th byte of a word is accepted.
//   With RxValid held high, one word takes 5 cycles.
//  Outside WRITE, MemWrite=0. MemAddress and MemWriteData hold their last values.
//  RxValid gaps stall the FSM in place with no state loss. Bytes offered in IDLE,
//   DONE or ERROR are not accepted (RxReady=0).
//  start is ignored while Busy=1. start on the same edge as an accept in LEN_LO, LEN_HI or DATA is ignored.
//  WordCount never exceeds MEMORY_DEPTH; addresses never wrap.
//  Reset mid-load aborts the load to IDLE with CPUReset=1. Words already written stay
//   in memory and are not re-checked.
// TESTING
//  1 start; bytes 02 00 | 78 56 34 12 | EF BE AD DE, RxValid held high ->
//    MemWrite at addr 0 data 32'h12345678, then addr 4 data 32'hDEADBEEF.
//    Done=1 and CPUReset=0 one cycle after the second strobe; WordCount=2.
//  2 Length 00 00 -> Error=1, CPUReset=1, no MemWrite. Length 21 00 (33) at
//    MEMORY_DEPTH=32 -> Error=1. Length 20 00 (32) + 128 bytes -> 32 writes, last at addr 124, Done=1.
//  3 Scenario 1 with 3-cycle RxValid gaps between bytes -> identical writes and data.
//    RxReady=0 in every WRITE cycle.
//  4 start pulses while Busy=1 and bytes presented in IDLE -> no effect, no accepts.
//  5 reset asserted after the 2nd data byte -> IDLE, CPUReset=1, WordCount=0, no MemWrite.
//    A fresh load after start succeeds.
//  6 After Done, start and load 1 word 13 00 00 00 ->
//    CPUReset=1 during the load, write 32'h00000013 at addr 0, Done=1 again.

Source files
------------

// File: rtl/mips_boot_loader_if.sv
// Byte-stream receive and program-memory write signals between the boot loader
// and its surroundings (byte source and instruction memory).
interface mips_boot_loader_if;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;

    modport slave (
        input  RxData, RxValid,
        output RxReady, MemWrite, MemAddress, MemWriteData
    );

    modport master (
        output RxData, RxValid,
        input  RxReady, MemWrite, MemAddress, MemWriteData
    );
endinterface

// File: rtl/mips_boot_loader.sv
// Boot loader: takes a length-prefixed little-endian byte image, writes it word by
// word into program memory and releases the MIPS core once the image is complete.
module mips_boot_loader #(
    parameter int MEMORY_DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    mips_boot_loader_if.slave   bus,
    output logic                CPUReset,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [15:0]         WordCount
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
    } state_t;

    localparam logic [15:0] DEPTH = 16'(MEMORY_DEPTH);

    state_t      state, state_next;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] len_rx;
    logic        len_bad;
    logic        last_word;

    // Ready depends only on state, so there is no path from RxValid to RxReady.
    assign bus.RxReady = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign bus.MemWrite = (state == WRITE);
    assign accept       = bus.RxValid && bus.RxReady;
    assign len_rx       = {bus.RxData, len[7:0]};
    assign len_bad      = (len_rx == 16'd0) || (len_rx > DEPTH);
    assign last_word    = (WordCount + 16'd1) == len;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        unique case (state)
            IDLE, DONE, ERROR: if (start) state_next = LEN_LO;
            LEN_LO:            if (accept) state_next = LEN_HI;
            LEN_HI:            if (accept) state_next = len_bad ? ERROR : DATA;
            DATA:              if (accept && byte_idx == 2'd3) state_next = WRITE;
            WRITE:             state_next = last_word ? DONE : DATA;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CPUReset         <= 1'b1;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Error            <= 1'b0;
            WordCount        <= 16'd0;
            len              <= 16'd0;
            byte_idx         <= 2'd0;
            word_buf         <= 24'd0;
            bus.MemAddress   <= 32'd0;
            bus.MemWriteData <= 32'd0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        Busy      <= 1'b1;
                        CPUReset  <= 1'b1;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                        WordCount <= 16'd0;
                    end
                end
                LEN_LO: if (accept) len[7:0] <= bus.RxData;
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.RxData;
                        byte_idx  <= 2'd0;
                        if (len_bad) begin
                            Busy  <= 1'b0;
                            Error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.RxData;
                            2'd1: word_buf[15:8]  <= bus.RxData;
                            2'd2: word_buf[23:16] <= bus.RxData;
                            default: begin
                                // Address and data are presented during WRITE and then held.
                                bus.MemAddress   <= {14'd0, WordCount, 2'b00};
                                bus.MemWriteData <= {bus.RxData, word_buf};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    WordCount <= WordCount + 16'd1;
                    if (last_word) begin
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        CPUReset <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized self-checking bench for mips_boot_loader: images are built from word
// lists and the observed memory writes are compared against those lists.
module tb_mips_boot_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        CPUReset, Busy, Done, Error;
    logic [15:0] WordCount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] img_words[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    mips_boot_loader_if bus ();

    mips_boot_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .CPUReset  (CPUReset),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .WordCount (WordCount)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobe and checks the source is stalled meanwhile.
    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_addr_q.push_back(bus.MemAddress);
            wr_data_q.push_back(bus.MemWriteData);
            wr_cyc_q.push_back(cyc);
            checks++;
            if (bus.RxReady !== 1'b0) begin
                errors++;
                $display("FAIL rxready_in_write: got %b want 0 at cycle %0d", bus.RxReady, cyc);
            end
        end
        cyc++;
    end

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    // Offer one byte after gap idle cycles; returns at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit spam);
        int n;
        start = spam;
        for (int i = 0; i < gap; i++) begin
            bus.RxValid = 1'b0;
            @(negedge clk);
        end
        bus.RxValid = 1'b1;
        bus.RxData  = b;
        n = 0;
        while (bus.RxReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte %h never accepted", b);
        end else begin
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] n, input int gap, input bit spam, input string name);
        bit ok;
        logic [7:0] b;
        ok = (n != 16'd0) && (n <= 16'(DEPTH));
        bus.RxValid = 1'b0;
        clear_writes();
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || CPUReset !== 1'b1 || Done !== 1'b0 || Error !== 1'b0 || WordCount !== 16'd0) begin
            errors++;
            $display("FAIL %s_start_flags: got busy=%b cpurst=%b done=%b err=%b wc=%0d want 1 1 0 0 0",
                     name, Busy, CPUReset, Done, Error, WordCount);
        end
        send_byte(n[7:0], gap, spam);
        send_byte(n[15:8], gap, spam);
        if (!ok) begin
            bus.RxValid = 1'b0;
            checks++;
            if (Error !== 1'b1 || CPUReset !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL %s_error_flags: got err=%b cpurst=%b busy=%b done=%b want 1 1 0 0",
                         name, Error, CPUReset, Busy, Done);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (wr_addr_q.size() != 0 || bus.RxReady !== 1'b0) begin
                errors++;
                $display("FAIL %s_error_quiet: got writes=%0d rxready=%b want 0 0",
                         name, wr_addr_q.size(), bus.RxReady);
            end
            return;
        end
        for (int w = 0; w < int'(n); w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((img_words[w] >> (8 * k)) & 32'hFF);
                send_byte(b, gap, spam);
            end
        end
        bus.RxValid = 1'b0;
        checks++;
        if (bus.MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL %s_write_latency: got memwrite=%b want 1 one cycle after last byte", name, bus.MemWrite);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b1 || CPUReset !== 1'b0 || Busy !== 1'b0 || Error !== 1'b0 || WordCount !== n) begin
            errors++;
            $display("FAIL %s_done_flags: got done=%b cpurst=%b busy=%b err=%b wc=%0d want 1 0 0 0 %0d",
                     name, Done, CPUReset, Busy, Error, WordCount, n);
        end
        checks++;
        if (wr_addr_q.size() != int'(n)) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", name, wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                checks++;
                if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== img_words[i]) begin
                    errors++;
                    $display("FAIL %s_write_%0d: got addr=%h data=%h want addr=%h data=%h",
                             name, i, wr_addr_q[i], wr_data_q[i], 32'(4 * i), img_words[i]);
                end
                if (gap == 0 && i > 0) begin
                    checks++;
                    if (wr_cyc_q[i] - wr_cyc_q[i-1] != 5) begin
                        errors++;
                        $display("FAIL %s_word_period_%0d: got %0d cycles want 5",
                                 name, i, wr_cyc_q[i] - wr_cyc_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic random_image(input int n);
        img_words.delete();
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
    endtask

    task automatic test_reset();
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        checks++;
        if (CPUReset !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || WordCount !== 16'd0 ||
            bus.RxReady !== 1'b0 || bus.MemWrite !== 1'b0 || bus.MemAddress !== 32'd0 || bus.MemWriteData !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got cpurst=%b busy=%b done=%b err=%b wc=%0d rdy=%b mw=%b addr=%h data=%h",
                     CPUReset, Busy, Done, Error, WordCount, bus.RxReady, bus.MemWrite, bus.MemAddress, bus.MemWriteData);
        end
    endtask

    task automatic test_basic();
        img_words = '{32'h12345678, 32'hDEADBEEF};
        run_load(16'd2, 0, 1'b0, "basic");
    endtask

    task automatic test_length_limits();
        run_load(16'd0, 0, 1'b0, "len0");
        run_load(16'd33, 0, 1'b0, "len33");
        random_image(DEPTH);
        run_load(16'(DEPTH), 0, 1'b0, "len32");
        checks++;
        if (wr_addr_q.size() == DEPTH && wr_addr_q[DEPTH-1] !== 32'd124) begin
            errors++;
            $display("FAIL len32_last_addr: got %h want 0000007c", wr_addr_q[DEPTH-1]);
        end
    endtask

    task automatic test_gaps();
        img_words = '{32'h12345678, 32'hDEADBEEF};
        run_load(16'd2, 3, 1'b0, "gaps");
    endtask

    task automatic test_ignore();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_writes();
        bus.RxValid = 1'b1;
        bus.RxData  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.RxReady !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_accept: got rxready=%b busy=%b want 0 0", bus.RxReady, Busy);
            end
        end
        bus.RxValid = 1'b0;
        random_image(3);
        run_load(16'd3, 1, 1'b1, "start_spam");
    endtask

    task automatic test_reset_mid_load();
        bus.RxValid = 1'b0;
        clear_writes();
        pulse_start();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        bus.RxValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (CPUReset !== 1'b1 || WordCount !== 16'd0 || Busy !== 1'b0 || Done !== 1'b0 ||
            bus.RxReady !== 1'b0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_load: got cpurst=%b wc=%0d busy=%b done=%b rdy=%b writes=%0d want 1 0 0 0 0 0",
                     CPUReset, WordCount, Busy, Done, bus.RxReady, wr_addr_q.size());
        end
        random_image(2);
        run_load(16'd2, 0, 1'b0, "after_reset");
    endtask

    task automatic test_reload();
        img_words = '{32'h00000013};
        run_load(16'd1, 0, 1'b0, "reload");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 8);
            random_image(n);
            run_load(16'(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        test_reset();
        test_basic();
        test_length_limits();
        test_gaps();
        test_ignore();
        test_reset_mid_load();
        test_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
